// File: rtl/s2p_pkg.sv
// Shared types and helpers for the s2p_slave serial-to-parallel receiver.
package s2p_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Consecutive good frames needed before link_ok asserts.
  localparam int unsigned LOCK_CNT = 2;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/s2p_sync.sv
// Two-flop synchronizer with synchronous active-low reset.
module s2p_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/s2p_slave.sv
// Serial-to-parallel receiver for the so/sclk/sld_n link.
// Optional link-dead timeout enabled by defining S2P_SLAVE_TIMEOUT_EN.
module s2p_slave
  import s2p_pkg::*;
#(
  parameter int unsigned      NBIT    = 64,
  parameter logic [NBIT-1:0]  DEF_VAL = '0,
  parameter int unsigned      TMO_CYC = 65535
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            si,
  input  logic            sclk,
  input  logic            sld_n,
  output logic [NBIT-1:0] po,
  output logic            po_vld,
  output logic            frame_err,
  output logic            link_ok
);

  localparam int unsigned IW = clogb2(NBIT);

  logic si_s2, sclk_s2, sld_s2;
  logic sclk_s3, rise_d;
  logic rise_q, si_q, sld_q;
  logic tmo;

  state_t          state_q, state_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [NBIT-1:0] shreg_q, shreg_n;
  logic [NBIT-1:0] po_n;
  logic            po_vld_n, err_n;
  logic [1:0]      gcnt_q, gcnt_n;

  s2p_sync u_sync_si   (.clk(clk), .rst_n(rst_n), .d(si),    .q(si_s2));
  s2p_sync u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk),  .q(sclk_s2));
  s2p_sync u_sync_sld  (.clk(clk), .rst_n(rst_n), .d(sld_n), .q(sld_s2));

  assign rise_d = sclk_s2 & ~sclk_s3;

  // si/sld_n are registered with rise so all three stay cycle-aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_s3 <= 1'b0;
      rise_q  <= 1'b0;
      si_q    <= 1'b0;
      sld_q   <= 1'b0;
    end else begin
      sclk_s3 <= sclk_s2;
      rise_q  <= rise_d;
      si_q    <= si_s2;
      sld_q   <= sld_s2;
    end
  end

`ifdef S2P_SLAVE_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Cleared on the pre-register rise so the timeout lands TMO_CYC clk after rise.
  always_ff @(posedge clk) begin
    if (!rst_n || rise_d) tmo_cnt <= '0;
    else if (tmo_cnt != TMO_CYC) tmo_cnt <= tmo_cnt + 32'd1;
  end

  assign tmo = !rise_d && (tmo_cnt == TMO_CYC - 1);
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign tmo        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      idx_q     <= '0;
      shreg_q   <= '0;
      po        <= DEF_VAL;
      po_vld    <= 1'b0;
      frame_err <= 1'b0;
      gcnt_q    <= '0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      shreg_q   <= shreg_n;
      po        <= po_n;
      po_vld    <= po_vld_n;
      frame_err <= err_n;
      gcnt_q    <= gcnt_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    shreg_n  = shreg_q;
    po_n     = po;
    po_vld_n = 1'b0;
    err_n    = 1'b0;
    gcnt_n   = gcnt_q;

    if (rise_q) begin
      if (state_q == HUNT || idx_q == '0) begin
        if (!sld_q) begin
          shreg_n    = '0;
          shreg_n[0] = si_q;
          idx_n      = IW'(1);
          state_n    = SHIFT;
        end else if (state_q == SHIFT) begin
          err_n   = 1'b1;
          gcnt_n  = '0;
          state_n = HUNT;
        end
      end else if (!sld_q) begin
        err_n      = 1'b1;
        gcnt_n     = '0;
        shreg_n    = '0;
        shreg_n[0] = si_q;
        idx_n      = IW'(1);
      end else begin
        shreg_n[idx_q] = si_q;
        if (idx_q == IW'(NBIT - 1)) begin
          idx_n    = '0;
          po_n     = shreg_n;
          po_vld_n = 1'b1;
          if (gcnt_q != 2'(LOCK_CNT)) gcnt_n = gcnt_q + 2'd1;
        end else begin
          idx_n = idx_q + IW'(1);
        end
      end
    end else if (tmo) begin
      state_n = HUNT;
      idx_n   = '0;
      po_n    = DEF_VAL;
      gcnt_n  = '0;
    end
  end

  assign link_ok = (gcnt_q == 2'(LOCK_CNT));

endmodule

// File: tb/tb_s2p_slave.sv
// Scoreboard bench for s2p_slave: NBIT=8, DEF_VAL=8'h3C, sclk phase 4 clk.
module tb_s2p_slave;

  logic       clk = 1'b0;
  logic       rst_n, si, sclk, sld_n;
  logic [7:0] po;
  logic       po_vld, frame_err, link_ok;

  s2p_slave #(.NBIT(8), .DEF_VAL(8'h3C), .TMO_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .si(si), .sclk(sclk), .sld_n(sld_n),
    .po(po), .po_vld(po_vld), .frame_err(frame_err), .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] po;
    bit         link;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] po_model = 8'h3C;
  int         gcnt_model = 0;
  int         last_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_bit(input logic b, input logic ld, output int c);
    si    = b;
    sld_n = ld;
    wait_clk(4);
    sclk = 1'b1;
    c    = cyc;
    wait_clk(4);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits);
    int c;
    for (int i = 0; i < nbits; i++) send_bit(d[i], (i == 0) ? 1'b0 : 1'b1, c);
    sld_n = 1'b1;
    if (nbits == 8) begin
      if (gcnt_model < 2) gcnt_model++;
      po_model = d;
      sbq.push_back('{is_err: 1'b0, po: d, link: (gcnt_model == 2), cyc: c + 4});
      last_c = c;
    end
  endtask

  task automatic expect_err();
    gcnt_model = 0;
    sbq.push_back('{is_err: 1'b1, po: po_model, link: 1'b0, cyc: 0});
  endtask

  // Monitor: pops one expectation per output pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (po_vld === 1'b1 || frame_err === 1'b1)) begin
      exp_t e;
      checks++;
      if (po_vld && frame_err) begin
        errors++;
        $display("FAIL pulse_overlap: po_vld and frame_err both high at cyc %0d", cyc);
      end else if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: po_vld=%b frame_err=%b po=%h at cyc %0d expected none",
                 po_vld, frame_err, po, cyc);
      end else begin
        e = sbq.pop_front();
        if (e.is_err != frame_err || po !== e.po || link_ok !== e.link ||
            (!e.is_err && cyc != e.cyc)) begin
          errors++;
          $display("FAIL %s: err=%b po=%h link=%b cyc=%0d expected err=%b po=%h link=%b cyc=%0d",
                   e.is_err ? "frame_err_event" : "po_vld_event", frame_err, po, link_ok, cyc,
                   e.is_err, e.po, e.link, e.cyc);
        end
      end
    end
  end

  initial begin
    int c;
    rst_n = 1'b0;
    si    = 1'b0;
    sclk  = 1'b0;
    sld_n = 1'b1;
    wait_clk(5);
    chk("reset_po", po, 8'h3C);
    chk("reset_po_vld", {7'b0, po_vld}, 8'h00);
    chk("reset_frame_err", {7'b0, frame_err}, 8'h00);
    chk("reset_link_ok", {7'b0, link_ok}, 8'h00);
    rst_n = 1'b1;
    wait_clk(3);

    send_frame(8'hA5, 8);
    send_frame(8'h5A, 8);

    send_frame(8'h33, 4);
    expect_err();
    send_frame(8'h0F, 8);

    send_frame(8'hFF, 8);
    expect_err();
    send_bit(1'b1, 1'b1, c);
    send_frame(8'h01, 8);

    send_frame(8'h55, 3);
    wait_clk(2);
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    gcnt_model = 0;
    po_model   = 8'h3C;
    chk("midreset_po", po, 8'h3C);
    chk("midreset_link_ok", {7'b0, link_ok}, 8'h00);
    send_frame(8'hC3, 8);
    send_frame(8'h96, 8);

`ifdef S2P_SLAVE_TIMEOUT_EN
    wait_clk(last_c + 102 - cyc);
    chk("pre_timeout_po", po, 8'h96);
    wait_clk(1);
    chk("timeout_po", po, 8'h3C);
    chk("timeout_link_ok", {7'b0, link_ok}, 8'h00);
`else
    wait_clk(200);
    chk("idle_po_hold", po, 8'h96);
    chk("idle_link_ok", {7'b0, link_ok}, 8'h01);
`endif

    wait_clk(10);
    chk("scoreboard_empty", 8'(sbq.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s2p_slave.md
# s2p_slave

Serial-to-parallel receiver for the three-wire load/clock/data link produced by our parallel-to-serial master (so/sclk/sld_n). It sits on the far board or CPLD, samples the asynchronous link in its own clock domain, rebuilds each NBIT-bit frame and presents it as a registered parallel word. It also reports frame errors and link health. Its register outputs feed board-control logic: reset fan-out, LED and present/alarm signals.

## Interface
- NBIT, 64: frame length in bits; ≥2.
- DEF_VAL, {NBIT{1'b0}}: value of po after reset and after a timeout.
- TMO_CYC, 65535: clk cycles without a detected sclk rise before a timeout. Used only with S2P_SLAVE_TIMEOUT_EN.
- clk, input, 1: receiver clock. All logic is on the rising edge.
- rst_n, input, 1: reset. Synchronous and active-low.
- si, input, 1: serial data from the master's so. Asynchronous.
- sclk, input, 1: serial clock from the master. Asynchronous.
- sld_n, input, 1: frame marker from the master. Low during bit 0. Asynchronous.
- po, output, NBIT: last good frame; bit k is the k-th bit received.
- po_vld, output, 1: one-cycle pulse when po is updated.
- frame_err, output, 1: one-cycle pulse when a malformed frame is discarded.
- link_ok, output, 1: high after 2 consecutive good frames.

## Operation
- Line conditioning:
  - si, sclk and sld_n each pass through a 2-flop synchronizer.
  - A third flop on sclk gives rise = sclk_s2 & ~sclk_s3.
  - si and sld_n are sampled only on cycles where rise = 1.
- Protocol:
  - Bits are sent LSB first.
  - Bit k is valid on si for one full sclk period. The receiver samples it at the k-th sclk rise.
  - sld_n is low only at the rise of bit 0.
- State machine HUNT / SHIFT, with bit index idx of width clogb2(NBIT):
  - HUNT: a rise with sld_n=0 stores si in bit 0, sets idx=1 and goes to SHIFT. A rise with sld_n=1 is ignored.
  - SHIFT, rise with sld_n=1 and idx<NBIT: store si in bit idx and increment idx.
  - SHIFT, rise with sld_n=0 and idx<NBIT (short frame): pulse frame_err, clear link_ok, discard the partial frame. This rise restarts the frame: bit 0 stored, idx=1, stay in SHIFT.
  - When idx reaches NBIT (last bit stored): the shift register is copied to po next cycle with po_vld=1. idx returns to 0 and the next rise must carry sld_n=0, which is handled as in HUNT.
  - SHIFT, idx==0 and a rise with sld_n=1 (long frame): pulse frame_err, clear link_ok, go to HUNT.
- po changes only on a complete good frame. It holds its value across errors.
- link_ok:
  - A 2-bit good-frame counter saturates at 2. link_ok = (count==2).
  - Any frame_err or timeout clears the counter.
- Reset (rst_n=0 at a clk edge) values:
  - Synchronizer flops, rise and idx: 0.
  - State: HUNT.
  - po: DEF_VAL.
  - po_vld, frame_err, link_ok: 0.
  - Reset mid-frame discards the partial frame.

## Timing
- Pin-to-rise latency: 3 clk from an sclk pin edge to rise=1 (2 synchronizer flops + edge flop). si and sld_n have the same sync depth, so they stay aligned with rise.
- Output latency: po/po_vld are registered 1 clk after the rise of bit NBIT-1, which is 4 clk after the pin edge.
- Input rule: each sclk high and low phase must last ≥3 clk. si and sld_n must be stable ≥3 clk around each sclk rise. Faster links are out of spec and may cause errors.
- Pulse timing: frame_err and po_vld never assert in the same cycle. Each is high for exactly 1 clk.

## Configuration
- S2P_SLAVE_TIMEOUT_EN defined:
  - A counter is cleared on every rise and on reset, and otherwise counts up.
  - When it reaches TMO_CYC: state goes to HUNT, po reloads DEF_VAL (fail-safe), link_ok and the good-frame counter clear, po_vld stays 0, no frame_err pulse. The counter then holds until the next rise.
- Not defined: no counter, no timeout; po holds indefinitely when the link is dead.

## Structure
- Shared package s2p_pkg holds:
  - the HUNT/SHIFT state encoding,
  - the clogb2 function,
  - the good-frame lock threshold constant (2).
- One sub-module, s2p_sync: a 2-flop synchronizer with synchronous active-low reset. It is instantiated 3 times, once each for si, sclk and sld_n.

## Test plan
Default bench settings: NBIT=8, DEF_VAL=8'h3C, sclk phase = 4 clk.
- Reset: hold rst_n=0 for 5 clk → po=8'h3C, po_vld=0, frame_err=0, link_ok=0.
- Good frame: send frame 8'hA5 → po=8'hA5 and po_vld pulses once 4 clk after the 8th sclk rising pin edge. Send 8'h5A next → link_ok=1 after the second po_vld.
- Short frame: sld_n low at the 5th rise, followed by a full frame 8'h0F → one frame_err, link_ok=0, po keeps its old value, then po=8'h0F.
- Long frame: a 9th rise with sld_n=1 after 8'hFF → po=8'hFF, then frame_err, state HUNT. The next proper frame 8'h01 → po=8'h01.
- Timeout (macro on, TMO_CYC=100): stop sclk after a good frame → po=8'h3C and link_ok=0 exactly 100 clk after the last rise. Without the macro, po holds.
- Reset mid-frame: assert rst_n=0 after 3 bits, release, send 8'hC3 → po=8'hC3, no frame_err.
